// File: rtl/fphub_accumulator_ctrl.sv
// Sequential accumulation controller feeding an external HUB adder (X/Y out, Z in).
// Optional macro FPHUB_ACC_ZERO_CANON_EN: store zeros captured into acc as +0.
module fphub_accumulator_ctrl #(
  parameter int M       = 4,
  parameter int E       = 4,
  parameter int ADD_LAT = 0,
  parameter int CW      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [E+M:0]     in_data,
  input  logic             in_last,
  output logic [E+M:0]     add_x,
  output logic [E+M:0]     add_y,
  input  logic [E+M:0]     add_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [E+M:0]     out_data,
  output logic [CW-1:0]    out_count
);

  localparam int W  = E + M + 1;
  localparam int LW = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_EXEC,
    S_DONE
  } state_t;

  state_t         state;
  logic [W-1:0]   acc;
  logic [W-1:0]   op;
  logic [W-1:0]   x_r;
  logic [CW-1:0]  cnt;
  logic [LW-1:0]  lat_cnt;
  logic           last_r;

  function automatic logic [W-1:0] canon(input logic [W-1:0] v);
`ifdef FPHUB_ACC_ZERO_CANON_EN
    if (v[W-2:0] == '0) return '0;
`endif
    return v;
  endfunction

  // add_x is a private copy of acc so the adder port only moves when an
  // add is launched, not when the first operand of a sequence lands in acc.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      acc     <= '0;
      op      <= '0;
      x_r     <= '0;
      cnt     <= '0;
      lat_cnt <= '0;
      last_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            acc   <= canon(in_data);
            cnt   <= CW'(1);
            state <= in_last ? S_DONE : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            op      <= in_data;
            x_r     <= acc;
            last_r  <= in_last;
            lat_cnt <= '0;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          lat_cnt <= lat_cnt + LW'(1);
          if (lat_cnt == LW'(ADD_LAT)) begin
            acc   <= canon(add_z);
            cnt   <= (cnt == '1) ? cnt : cnt + CW'(1);
            state <= last_r ? S_DONE : S_ACCUM;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // in_ready is masked by rst so it reads 0 throughout reset.
  assign in_ready  = ~rst & ((state == S_IDLE) | (state == S_ACCUM));
  assign out_valid = (state == S_DONE);
  assign out_data  = acc;
  assign out_count = cnt;
  assign add_x     = x_r;
  assign add_y     = op;

endmodule

// File: tb/tb_fphub_accumulator_ctrl.sv
// Randomized self-checking bench: a combinational-adder instance and a
// two-cycle-adder instance with a 2-bit counter, checked against a sequence model.
module tb_fphub_accumulator_ctrl;

  localparam int M    = 4;
  localparam int E    = 4;
  localparam int W    = E + M + 1;
  localparam int NDUT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid  [NDUT];
  logic         in_ready  [NDUT];
  logic [W-1:0] in_data   [NDUT];
  logic         in_last   [NDUT];
  logic [W-1:0] add_x     [NDUT];
  logic [W-1:0] add_y     [NDUT];
  logic [W-1:0] add_z     [NDUT];
  logic         out_valid [NDUT];
  logic         out_ready [NDUT];
  logic [W-1:0] out_data  [NDUT];
  logic [7:0]   out_count [NDUT];
  logic         force_en  [NDUT];
  logic [W-1:0] force_val [NDUT];

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] seq_buf [32];

  // Stand-in adder arithmetic; any deterministic non-symmetric function works.
  function automatic logic [W-1:0] fn(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [31:0] s;
    s = 32'(x) + 32'(y) * 3 + 1;
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] canon_b(input logic [W-1:0] v);
`ifdef FPHUB_ACC_ZERO_CANON_EN
    if (v[W-2:0] == 0) return '0;
`endif
    return v;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic int maxc_of(input int d);
    return (d == 0) ? 255 : 3;
  endfunction

  function automatic logic [W-1:0] model_z(input int d, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    return force_en[d] ? force_val[d] : fn(x, y);
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 0 : 2;
    localparam int CWG = (g == 0) ? 8 : 2;
    logic [CWG-1:0] cnt_w;
    logic [W-1:0]   z_model;

    if (LAT == 0) begin : g_comb
      assign z_model = fn(add_x[g], add_y[g]);
    end else begin : g_pipe
      logic [W-1:0] pipe [LAT];
      always @(posedge clk) begin
        pipe[0] <= fn(add_x[g], add_y[g]);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
      assign z_model = pipe[LAT-1];
    end

    assign add_z[g]     = force_en[g] ? force_val[g] : z_model;
    assign out_count[g] = 8'(cnt_w);

    fphub_accumulator_ctrl #(.M(M), .E(E), .ADD_LAT(LAT), .CW(CWG)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .in_last   (in_last[g]),
      .add_x     (add_x[g]),
      .add_y     (add_y[g]),
      .add_z     (add_z[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .out_count (cnt_w)
    );
  end

  // Drives seq_buf[0..n-1] into DUT d and checks every cycle against the
  // folded sum; called at a negedge with DUT d idle.
  task automatic run_seq(input int d, input int n, input bit gaps, input int bp);
    logic [W-1:0] acc_e;
    int cnt_e;
    int t;
    int ng;
    logic last;
    acc_e = '0;
    cnt_e = 0;
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      ng = gaps ? $urandom_range(0, 2) : 0;
      repeat (ng) begin
        @(negedge clk);
        vectors++;
        if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0) begin
          miscompares++;
          $display("FAIL wait_hold d%0d: in_ready=%b out_valid=%b want 1/0", d, in_ready[d], out_valid[d]);
        end
      end
      in_valid[d] = 1'b1;
      in_data[d]  = seq_buf[i];
      in_last[d]  = last;
      t = 0;
      while (in_ready[d] !== 1'b1 && t < 50) begin
        @(negedge clk);
        t++;
      end
      vectors++;
      if (in_ready[d] !== 1'b1) begin
        miscompares++;
        $display("FAIL accept_timeout d%0d: in_ready=%b want 1", d, in_ready[d]);
      end
      @(posedge clk);
      @(negedge clk);
      in_valid[d] = 1'b0;
      in_last[d]  = 1'b0;
      if (i == 0) begin
        acc_e = canon_b(seq_buf[0]);
        cnt_e = 1;
      end else begin
        for (int j = 0; j <= lat_of(d); j++) begin
          if (j > 0) @(negedge clk);
          vectors++;
          if (in_ready[d] !== 1'b0 || out_valid[d] !== 1'b0) begin
            miscompares++;
            $display("FAIL exec_flags d%0d cyc%0d: in_ready=%b out_valid=%b want 0/0", d, j, in_ready[d], out_valid[d]);
          end
          vectors++;
          if (add_x[d] !== acc_e) begin
            miscompares++;
            $display("FAIL exec_add_x d%0d cyc%0d: got %h want %h", d, j, add_x[d], acc_e);
          end
          vectors++;
          if (add_y[d] !== seq_buf[i]) begin
            miscompares++;
            $display("FAIL exec_add_y d%0d cyc%0d: got %h want %h", d, j, add_y[d], seq_buf[i]);
          end
        end
        @(negedge clk);
        acc_e = canon_b(model_z(d, acc_e, seq_buf[i]));
        cnt_e = (cnt_e < maxc_of(d)) ? cnt_e + 1 : maxc_of(d);
      end
      vectors++;
      if (last ? (out_valid[d] !== 1'b1) : (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0)) begin
        miscompares++;
        $display("FAIL step_state d%0d elem%0d: out_valid=%b in_ready=%b last=%b", d, i, out_valid[d], in_ready[d], last);
      end
    end
    for (int b = 0; b <= bp; b++) begin
      vectors++;
      if (out_valid[d] !== 1'b1 || in_ready[d] !== 1'b0) begin
        miscompares++;
        $display("FAIL done_flags d%0d bp%0d: out_valid=%b in_ready=%b want 1/0", d, b, out_valid[d], in_ready[d]);
      end
      vectors++;
      if (out_data[d] !== acc_e) begin
        miscompares++;
        $display("FAIL out_data d%0d bp%0d: got %h want %h", d, b, out_data[d], acc_e);
      end
      vectors++;
      if (out_count[d] !== 8'(cnt_e)) begin
        miscompares++;
        $display("FAIL out_count d%0d bp%0d: got %0d want %0d", d, b, out_count[d], cnt_e);
      end
      if (b < bp) @(negedge clk);
    end
    out_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[d] = 1'b0;
    vectors++;
    if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
      miscompares++;
      $display("FAIL post_handshake d%0d: out_valid=%b in_ready=%b want 0/1", d, out_valid[d], in_ready[d]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      vectors++;
      if (in_ready[d] !== 1'b0 || out_valid[d] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_flags d%0d: in_ready=%b out_valid=%b want 0/0", d, in_ready[d], out_valid[d]);
      end
      vectors++;
      if (out_data[d] !== '0 || out_count[d] !== 8'd0 || add_x[d] !== '0 || add_y[d] !== '0) begin
        miscompares++;
        $display("FAIL reset_regs d%0d: data=%h count=%0d x=%h y=%h want 0", d, out_data[d], out_count[d], add_x[d], add_y[d]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      vectors++;
      if (in_ready[d] !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_release d%0d: in_ready=%b want 1", d, in_ready[d]);
      end
    end
  endtask

  task automatic test_single();
    seq_buf[0] = 9'h0A5;
    run_seq(0, 1, 1'b0, 0);
    seq_buf[0] = 9'h100;
    run_seq(0, 1, 1'b0, 1);
    seq_buf[0] = 9'h077;
    run_seq(1, 1, 1'b0, 0);
  endtask

  task automatic test_two_comb();
    seq_buf[0] = 9'h0A5;
    seq_buf[1] = 9'h093;
    run_seq(0, 2, 1'b0, 1);
  endtask

  task automatic test_zero_canon();
    force_en[0]  = 1'b1;
    force_val[0] = 9'h100;
    seq_buf[0] = 9'h0A5;
    seq_buf[1] = 9'h1A5;
    run_seq(0, 2, 1'b0, 0);
    force_en[0] = 1'b0;
  endtask

  task automatic test_latency();
    seq_buf[0] = 9'h0A5;
    seq_buf[1] = 9'h093;
    seq_buf[2] = 9'h1C2;
    run_seq(1, 3, 1'b0, 0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) seq_buf[i] = 9'($urandom_range(0, 511));
    run_seq(1, 5, 1'b0, 5);
    for (int i = 0; i < 9; i++) seq_buf[i] = 9'($urandom_range(0, 511));
    run_seq(0, 9, 1'b1, 5);
  endtask

  task automatic test_random();
    int d;
    int n;
    for (int it = 0; it < 30; it++) begin
      d = $urandom_range(0, 1);
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        seq_buf[i] = 9'($urandom_range(0, 511));
        if ($urandom_range(0, 7) == 0) seq_buf[i][W-2:0] = '0;
      end
      run_seq(d, n, 1'b1, $urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_mid();
    in_valid[1] = 1'b1;
    in_data[1]  = 9'h0A5;
    in_last[1]  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_data[1]  = 9'h093;
    in_last[1]  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[1] = 1'b0;
    in_last[1]  = 1'b0;
    vectors++;
    if (in_ready[1] !== 1'b0 || add_y[1] !== 9'h093) begin
      miscompares++;
      $display("FAIL mid_exec d1: in_ready=%b add_y=%h want 0/093", in_ready[1], add_y[1]);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (out_valid[1] !== 1'b0 || add_x[1] !== '0 || add_y[1] !== '0) begin
      miscompares++;
      $display("FAIL mid_reset d1: out_valid=%b x=%h y=%h want 0", out_valid[1], add_x[1], add_y[1]);
    end
    vectors++;
    if (out_data[1] !== '0 || out_count[1] !== 8'd0 || in_ready[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_regs d1: data=%h count=%0d in_ready=%b want 0", out_data[1], out_count[1], in_ready[1]);
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      vectors++;
      if (in_ready[1] !== 1'b1 || out_valid[1] !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_release d1: in_ready=%b out_valid=%b want 1/0", in_ready[1], out_valid[1]);
      end
    end
    seq_buf[0] = 9'h031;
    run_seq(1, 1, 1'b0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      in_valid[d]  = 1'b0;
      in_data[d]   = '0;
      in_last[d]   = 1'b0;
      out_ready[d] = 1'b0;
      force_en[d]  = 1'b0;
      force_val[d] = '0;
    end
    test_reset();
    test_single();
    test_two_comb();
    test_zero_canon();
    test_latency();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
